// File: rtl/imem_server_pkg.sv
// imem_pkg: shared constants and state type for the instruction-memory server.
//   NOP_INST      - word presented whenever no valid instruction is served
//   HALT_OP       - opcode of the halt encoding
//   HALT_WORD_DEF - full halt encoding (HALT_OP with all other fields zero)
//   imem_state_t  - LOAD / READY / RUN / HALT
package imem_pkg;

    localparam logic [31:0] NOP_INST      = 32'h0000_0000;
    localparam logic [5:0]  HALT_OP       = 6'h3F;
    localparam logic [31:0] HALT_WORD_DEF = {HALT_OP, 26'd0};

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        READY = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } imem_state_t;

endpackage

// File: rtl/imem_server_if.sv
// imem_server_if: fetch and program-load signals between a host/cpu and the
// instruction-memory server.
//   pc         - byte address from the cpu fetch stage
//   inst       - registered instruction back to the cpu
//   load_valid - load word present
//   load_ready - server accepts a load word this cycle
//   load_data  - program word
//   load_last  - marks the final program word
// master: cpu/host side.  slave: server side.
interface imem_server_if;

    logic [31:0] pc;
    logic [31:0] inst;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;

    modport master (
        output pc,
        output load_valid,
        output load_data,
        output load_last,
        input  inst,
        input  load_ready
    );

    modport slave (
        input  pc,
        input  load_valid,
        input  load_data,
        input  load_last,
        output inst,
        output load_ready
    );

endinterface

// File: rtl/imem_server_array.sv
// imem_array: DEPTH x 32 single-write, synchronous-read RAM.
//   clk   - clock
//   we    - write enable
//   waddr - write word address
//   wdata - write data
//   raddr - read word address, sampled on posedge
//   rdata - read data, valid the cycle after raddr is sampled
// No reset: contents persist across resets of the surrounding logic.
module imem_array #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/imem_server.sv
// imem_server: instruction-side responder for the 5-stage cpu.
// A program image is loaded through the valid/ready load port, then after a
// start pulse each cycle's pc is served on inst with one cycle of latency.
//   clk       - system clock
//   reset     - asynchronous active-low reset
//   bus       - imem_server_if.slave (pc/inst fetch, load port)
//   start     - one-cycle pulse; begin serving (honoured only in READY)
//   running   - high in RUN
//   done      - halt word has been served; sticky until reset
//   misalign  - sticky; a pc with pc[1:0]!=0 was seen in RUN
//   oob       - sticky; a pc word index >= DEPTH was seen in RUN
//   fetch_cnt - instructions served in RUN, saturating
module imem_server
    import imem_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter int          ADDR_W    = $clog2(DEPTH),
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic                clk,
    input  logic                reset,
    imem_server_if.slave        bus,
    input  logic                start,
    output logic                running,
    output logic                done,
    output logic                misalign,
    output logic                oob,
    output logic [31:0]         fetch_cnt
);

    imem_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg;
    logic              nop_reg, nop_next;
    logic              misalign_reg, oob_reg;
    logic [31:0]       cnt_reg;

    logic [ADDR_W-1:0] word_index;
    logic              fault_align, fault_range;
    logic [31:0]       rdata;
    logic              load_fire;
    logic              halt_seen;
    logic              serve;

    assign word_index  = bus.pc[ADDR_W+1:2];
    assign fault_align = (bus.pc[1:0] != 2'b00);
    assign fault_range = (bus.pc[31:ADDR_W+2] != '0);

    assign load_fire = (state_reg == LOAD) && bus.load_valid;

    imem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (load_fire),
        .waddr (ptr_reg),
        .wdata (bus.load_data),
        .raddr (word_index),
        .rdata (rdata)
    );

    // The RAM read is registered, so the halt word is only visible while it
    // is already being presented on inst. The edge that ends that cycle moves
    // to HALT and does not count as another fetch.
    assign halt_seen = (state_reg == RUN) && !nop_reg && (rdata == HALT_WORD);
    assign serve     = (state_reg == RUN) && !halt_seen;

    always_comb begin
        state_next = state_reg;
        nop_next   = 1'b1;
        case (state_reg)
            LOAD: begin
                if (load_fire && (bus.load_last || ptr_reg == ADDR_W'(DEPTH - 1))) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (halt_seen) begin
                    state_next = HALT;
                end else begin
                    // Faulting pcs get a NOP instead of the RAM word.
                    nop_next = fault_align || fault_range;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= LOAD;
            ptr_reg      <= '0;
            nop_reg      <= 1'b1;
            misalign_reg <= 1'b0;
            oob_reg      <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            state_reg <= state_next;
            nop_reg   <= nop_next;
            if (load_fire) begin
                ptr_reg <= ptr_reg + ADDR_W'(1);
            end
            if (serve) begin
                misalign_reg <= misalign_reg | fault_align;
                oob_reg      <= oob_reg | fault_range;
                if (cnt_reg != 32'hFFFF_FFFF) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    end

    // nop_reg is cleared asynchronously to 1, so inst drops to NOP at once
    // when reset is asserted even though the RAM output is not reset.
    assign bus.inst       = nop_reg ? NOP_INST : rdata;
    assign bus.load_ready = (state_reg == LOAD);
    assign running        = (state_reg == RUN);
    assign done           = (state_reg == HALT);
    assign misalign       = misalign_reg;
    assign oob            = oob_reg;
    assign fetch_cnt      = cnt_reg;

endmodule

// File: tb/tb_imem_server.sv
// tb_imem_server: randomized self-checking bench for imem_server with a
// queue-based scoreboard. A behavioural model (word array, counters, sticky
// flags) produces expected fetch responses; a monitor compares them on the
// falling edge after each served cycle.
module tb_imem_server;

    localparam int          DEPTH  = 256;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;
    localparam logic [31:0] SUB_V0 = 32'h0042_1006;
    localparam logic [31:0] SUB_V1 = 32'h0063_1806;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        running, done, misalign, oob;
    logic [31:0] fetch_cnt;

    imem_server_if bus ();

    imem_server #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (bus),
        .start     (start),
        .running   (running),
        .done      (done),
        .misalign  (misalign),
        .oob       (oob),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    logic [31:0] mem_model [DEPTH];
    int          ptr_m;
    bit          loading_m;
    bit          halt_served_m;
    bit          mis_m, oob_m;
    logic [31:0] cnt_m;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
        logic        oob;
        logic        run;
        logic        done;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ptr_m         = 0;
        loading_m     = 1'b1;
        halt_served_m = 1'b0;
        mis_m         = 1'b0;
        oob_m         = 1'b0;
        cnt_m         = 32'd0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_inst"},       bus.inst, 32'h0);
        check({tag, "_load_ready"}, {31'd0, bus.load_ready}, 32'd1);
        check({tag, "_running"},    {31'd0, running}, 32'd0);
        check({tag, "_done"},       {31'd0, done}, 32'd0);
        check({tag, "_misalign"},   {31'd0, misalign}, 32'd0);
        check({tag, "_oob"},        {31'd0, oob}, 32'd0);
        check({tag, "_fetch_cnt"},  fetch_cnt, 32'd0);
    endtask

    // One load-port transfer attempt; load_ready is compared against the
    // model's view of whether the block should still be loading.
    task automatic load_word(input logic [31:0] data, input logic last, input logic with_start);
        bit accept;
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_data  = data;
        bus.load_last  = last;
        start          = with_start;
        accept         = loading_m;
        check("load_ready", {31'd0, bus.load_ready}, {31'd0, accept});
        @(posedge clk);
        if (accept) begin
            mem_model[ptr_m] = data;
            ptr_m++;
            if (last || ptr_m == DEPTH) loading_m = 1'b0;
        end
        $display("load  data=%h last=%0d accepted=%0d", data, last, accept);
        #1;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        start          = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Drive one pc and record what the served cycle should produce.
    task automatic issue_pc(input logic [31:0] p);
        exp_t e;
        bit   fa, fr;
        @(negedge clk);
        bus.pc = p;
        @(posedge clk);
        #1;
        e.pc = p;
        if (halt_served_m) begin
            e.inst = 32'h0;
            e.run  = 1'b0;
            e.done = 1'b1;
        end else begin
            fa    = (p % 4) != 0;
            fr    = (p / 4) >= DEPTH;
            mis_m = mis_m | fa;
            oob_m = oob_m | fr;
            if (cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
            e.inst = (fa || fr) ? 32'h0 : mem_model[p / 4];
            e.run  = 1'b1;
            e.done = 1'b0;
            if (e.inst == HALT_W) halt_served_m = 1'b1;
        end
        e.mis = mis_m;
        e.oob = oob_m;
        e.cnt = cnt_m;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 4) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d responses pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: compares the presented response with the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("inst",      bus.inst, e.inst);
            check("misalign",  {31'd0, misalign}, {31'd0, e.mis});
            check("oob",       {31'd0, oob}, {31'd0, e.oob});
            check("running",   {31'd0, running}, {31'd0, e.run});
            check("done",      {31'd0, done}, {31'd0, e.done});
            check("fetch_cnt", fetch_cnt, e.cnt);
            $display("fetch pc=%h inst=%h cnt=%0d mis=%0d oob=%0d done=%0d",
                     e.pc, bus.inst, fetch_cnt, misalign, oob, done);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] p;
        int          r;

        bus.pc         = 32'h0;
        bus.load_valid = 1'b0;
        bus.load_data  = 32'h0;
        bus.load_last  = 1'b0;
        model_reset();

        #2;
        check_reset_outputs("por");
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Full image with no load_last: loading stops after DEPTH words.
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            if (d == HALT_W) d = d ^ 32'h1;
            repeat ($urandom_range(0, 1)) @(posedge clk);
            load_word(d, 1'b0, 1'b0);
        end
        load_word(32'hDEAD_BEEF, 1'b0, 1'b0);
        @(negedge clk);
        check("full_load_ready", {31'd0, bus.load_ready}, 32'd0);
        check("full_running",    {31'd0, running}, 32'd0);

        pulse_start();
        check("start_running", {31'd0, running}, 32'd1);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                p = ($urandom_range(0, DEPTH - 1) * 4) | $urandom_range(1, 3);
            end else if (r == 1) begin
                p = (r == 1 && $urandom_range(0, 1) == 1) ? ($urandom | 32'h0000_0400)
                                                         : (32'h400 + $urandom_range(0, 1000) * 4);
            end else begin
                p = $urandom_range(0, DEPTH - 1) * 4;
            end
            issue_pc(p);
        end
        issue_pc(32'h0000_0006);
        issue_pc(32'h0000_0400);
        drain();

        // Asynchronous reset between edges while running.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Short program; start arriving with the last word is ignored.
        load_word(SUB_V0, 1'b0, 1'b0);
        load_word(SUB_V1, 1'b0, 1'b0);
        load_word(HALT_W, 1'b1, 1'b1);
        @(negedge clk);
        check("prog_running", {31'd0, running}, 32'd0);
        check("prog_ready",   {31'd0, bus.load_ready}, 32'd0);

        // Backpressure in READY: these words must not reach the array.
        load_word(32'h1234_5678, 1'b0, 1'b0);
        load_word(32'h1234_5678, 1'b1, 1'b0);

        pulse_start();
        issue_pc(32'h0000_000C);
        issue_pc(32'h0000_0006);
        issue_pc(32'h0000_0000);
        issue_pc(32'h0000_0004);
        issue_pc(32'h0000_0400);
        issue_pc(32'h0000_0008);
        issue_pc(32'h0000_0000);
        issue_pc(32'h0000_0004);
        drain();

        // HALT ignores both the load port and start.
        load_word(32'hAAAA_5555, 1'b1, 1'b1);
        issue_pc(32'h0000_0000);
        drain();
        check("halt_done", {31'd0, done}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_server.md
Name: imem_server

Overview:
- Instruction-side responder for the 5-stage MIPS `cpu`. It is the other end of the fetch interface: the cpu drives `pc` and this block returns `inst`.
- Holds a program image in a word array. The image is loaded through a valid/ready load port, then served to the cpu one instruction per cycle with 1-cycle registered latency.
- Detects a halt word, misaligned PCs and out-of-range PCs. Counts instructions served.
- Replaces hand-driven `inst` stimulus in cpu benches and on Veloce.

Parameters:
- DEPTH, 256, number of 32-bit instruction words; power of two.
- ADDR_W, $clog2(DEPTH), word-address width.
- HALT_WORD, 32'hFC00_0000, encoding that ends execution (opcode 6'h3F, otherwise zero).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- pc  in  32  byte address from cpu stage 1.
- inst  out  32  instruction to cpu; registered.
- load_valid  in  1  load word present.
- load_ready  out  1  block accepts a load word this cycle.
- load_data  in  32  program word; written at the internal load pointer.
- load_last  in  1  marks final load word.
- start  in  1  one-cycle pulse; begin serving.
- running  out  1  high in RUN state.
- done  out  1  halt word served; sticky until reset.
- misalign  out  1  sticky; a pc with pc[1:0]!=0 was seen in RUN.
- oob  out  1  sticky; pc word index >= DEPTH was seen in RUN.
- fetch_cnt  out  32  instructions served in RUN; saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset (reset==0, async):
  - State = LOAD; load pointer = 0.
  - inst = NOP_INST (32'h0); load_ready = 1.
  - running, done, misalign, oob = 0; fetch_cnt = 0.
  - Array contents are not cleared.
- States are LOAD, READY, RUN, HALT.
- LOAD:
  - load_ready = 1.
  - On load_valid && load_ready: mem[ptr] <= load_data and ptr++.
  - If load_last is set, or ptr == DEPTH-1 on that transfer: go to READY, load_ready <= 0.
  - A start pulse while in LOAD is ignored.
- READY: hold, inst = NOP. start -> RUN.
- RUN:
  - Word index = pc[ADDR_W+1:2].
  - Each cycle, inst <= mem[index]. pc sampled at edge N appears on inst after edge N (1-cycle latency).
  - pc[1:0]!=0: inst <= NOP, misalign <= 1.
  - pc[31:ADDR_W+2]!=0: inst <= NOP, oob <= 1.
  - If both faults hold, both flags set.
  - fetch_cnt++ on every RUN cycle, including NOP substitutions; saturates.
  - When the word selected is HALT_WORD: inst <= HALT_WORD that cycle, then go to HALT.
- HALT:
  - inst = NOP every cycle; done = 1; running = 0; fetch_cnt frozen.
  - load_valid and start are ignored. Only reset leaves HALT.
- Simultaneous load_valid && load_last && start in LOAD: the load completes and start is ignored (next state READY).
- Reset mid-RUN: outputs return to reset values immediately. The program stays in the array but must be reloaded, since ptr = 0.
- Load pointer reaching DEPTH-1 without load_last: the final write occurs and the state goes to READY (no wrap).

Decomposition:
- Package `imem_pkg`:
  - NOP_INST = 32'h0.
  - HALT_OP = 6'h3F.
  - typedef enum logic [1:0] {LOAD, READY, RUN, HALT} imem_state_t.
- Instruction-field constants (ADDI_op, register names v0/v1) stay in AluCtrlSig_pkg and are reused by benches.
- One sub-module, `imem_array`: DEPTH x 32 synchronous-read, single-write RAM (we, waddr, wdata, raddr, rdata). This gives a clean Veloce memory mapping.
- imem_server holds the FSM, load pointer, fault checks, counter and output mux.

Test Plan:
- Load 3 words: 32'h0042_1006 (SUB v0), 32'h0063_1806 (SUB v1), HALT_WORD, last on the third; then start. Drive pc = 0, 4, 8 -> inst = 32'h0042_1006, 32'h0063_1806, 32'hFC00_0000 on successive cycles; next cycle done = 1, inst = 0, fetch_cnt = 3.
- Backpressure: in READY, assert load_valid with 32'h1234_5678 -> load_ready = 0 and mem unchanged. Check by reading word ptr after start.
- In RUN, drive pc = 32'h0000_0006 -> next inst = 0, misalign = 1 and stays 1. Following pc = 0 still returns mem[0].
- With DEPTH = 256, pc = 32'h0000_0400 -> inst = 0, oob = 1, fetch_cnt incremented.
- Pull reset low mid-RUN asynchronously (between edges) -> inst = 0, running = 0, fetch_cnt = 0, load_ready = 1 before the next posedge.
- Load 256 words with no load_last -> after the 256th transfer state = READY, load_ready = 0. A 257th load_valid is not accepted.
